// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// default parameters, skid FIFO geometry and the address range helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int          MEM_WORDS_DEFAULT = 32;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W    = 64;

    // Widened compare so that 4*words never wraps for large memories.
    function automatic logic addr_in_range(input logic [31:0] addr, input int words);
        logic [33:0] limit;
        limit = 34'(words) << 2;
        return ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer holding {pc, inst} pairs between the instruction
// memory and decode; flush empties it in one cycle and wins over push/pop.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ENTRY_W-1:0]    push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [ENTRY_W-1:0]    head_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [ENTRY_W-1:0]    mem_reg [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_reg;
    logic [FIFO_PTR_W-1:0] rd_ptr_reg;
    logic [FIFO_CNT_W-1:0] count_reg;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push && !flush && (wr_ptr_reg == FIFO_PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential fetches to a one-cycle
// instruction memory, buffers returns in a skid FIFO and handles redirects/faults.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fault,
    output logic [1:0]  state
);

    state_t state_reg;
    state_t state_next;

    logic [31:0] pc_reg;
    logic [31:0] tag_reg;
    logic        inflight_reg;
    logic        fault_reg;

    logic [FIFO_CNT_W-1:0] count;
    logic [ENTRY_W-1:0]    head;

    logic       pop;
    logic       in_run;
    logic       redirect_take;
    logic       redirect_bad;
    logic [2:0] level;
    logic       issue_slot;
    logic       issue;
    logic       issue_fault;
    logic       fault_event;
    logic       fifo_push;
    logic       fifo_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (fault_event) state_next = ST_FAULT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pop           = inst_valid & inst_ready;
        in_run        = (state_reg == ST_RUN);
        redirect_take = in_run & redirect_valid;
        redirect_bad  = (redirect_pc[1:0] != 2'b00) || !addr_in_range(redirect_pc, MEM_WORDS);
        // Projected occupancy once the in-flight word lands and any pop retires.
        level         = 3'(count) + 3'(inflight_reg) - 3'(pop);
        issue_slot    = in_run & ~redirect_valid & (level < 3'(FIFO_DEPTH));
        issue         = issue_slot & addr_in_range(pc_reg, MEM_WORDS);
        issue_fault   = issue_slot & ~addr_in_range(pc_reg, MEM_WORDS);
        fault_event   = (redirect_take & redirect_bad) | issue_fault;
        fifo_flush    = redirect_take;
        fifo_push     = inflight_reg & ~redirect_take;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            tag_reg      <= '0;
            inflight_reg <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (fault_event) begin
                fault_reg <= 1'b1;
            end
            if (redirect_take && !redirect_bad) begin
                pc_reg <= redirect_pc;
            end else if (issue) begin
                pc_reg  <= pc_reg + 32'd4;
                tag_reg <= pc_reg;
            end
        end
    end

    fetch_skid_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({tag_reg, imem_inst}),
        .pop       (pop),
        .flush     (fifo_flush),
        .head_data (head),
        .count     (count)
    );

    assign imem_addr  = pc_reg;
    assign inst_valid = (count != '0);
    assign inst_pc    = head[63:32];
    assign inst_data  = head[31:0];
    assign fault      = fault_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected PCs are queued as stimulus is
// driven, deliveries are captured at the falling edge and scored by each test.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_WORDS = 32;
    localparam logic [31:0] MEM_END   = 32'h0000_0080;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fault;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    int delivered = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_pc_q[$];
    logic [31:0] got_data_q[$];

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fault          (fault),
        .state          (state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a * 32'h0000_0101);
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: samples the address on posedge, returns the word after it.
    always @(posedge clock) imem_inst <= mem_word(imem_addr);

    always @(negedge clock) begin
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            got_pc_q.push_back(inst_pc);
            got_data_q.push_back(inst_data);
            delivered <= delivered + 1;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++; if (state !== 2'd0) begin fails++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        tests++; if (imem_addr !== RESET_PC) begin fails++; $display("[TB] FAIL reset_imem_addr got=%h exp=%h", imem_addr, RESET_PC); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        tests++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_inst_regs got data=%h pc=%h exp 0", inst_data, inst_pc); end
        tests++; if (fault !== 1'b0) begin fails++; $display("[TB] FAIL reset_fault got=%b exp=0", fault); end
        reset = 1'b0;
        tick;
        tests++; if (state !== 2'd0 || imem_addr !== RESET_PC) begin fails++; $display("[TB] FAIL idle_hold got state=%0d addr=%h exp 0/%h", state, imem_addr, RESET_PC); end
        $display("[TB] reset checks done");
    endtask

    task automatic test_stream;
        int d0;
        logic [31:0] gp, gd, ep;
        for (int i = 0; i < 16; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        inst_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tests++; if (state !== 2'd1 || inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL start_e0 got state=%0d valid=%b exp 1/0", state, inst_valid); end
        tick;
        tests++; if (inst_valid !== 1'b0 || imem_addr !== RESET_PC + 32'd4) begin fails++; $display("[TB] FAIL start_e1 got valid=%b addr=%h exp 0/%h", inst_valid, imem_addr, RESET_PC + 32'd4); end
        tick;
        tests++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin fails++; $display("[TB] FAIL start_e2 got valid=%b pc=%h exp 1/%h", inst_valid, inst_pc, RESET_PC); end
        tests++; if (inst_data !== mem_word(RESET_PC)) begin fails++; $display("[TB] FAIL start_e2_data got=%h exp=%h", inst_data, mem_word(RESET_PC)); end
        d0 = delivered;
        repeat (6) tick;
        tests++; if (delivered - d0 !== 6) begin fails++; $display("[TB] FAIL throughput got=%0d exp=6", delivered - d0); end
        while (got_pc_q.size() > 0) begin
            gp = got_pc_q.pop_front(); gd = got_data_q.pop_front();
            if (exp_q.size() > 0) ep = exp_q.pop_front(); else ep = 32'hFFFF_FFFF;
            tests++;
            if (gp !== ep || gd !== mem_word(ep)) begin fails++; $display("[TB] FAIL stream_order got pc=%h data=%h exp pc=%h data=%h", gp, gd, ep, mem_word(ep)); end
            else $display("[TB] deliver pc=%h data=%h", gp, gd);
        end
    endtask

    task automatic test_stall;
        int d0;
        logic [31:0] hold, gp, gd, ep;
        inst_ready = 1'b0;
        hold = exp_q[0];
        d0 = delivered;
        for (int k = 0; k < 5; k++) begin
            tick;
            tests++; if (inst_valid !== 1'b1 || inst_pc !== hold || inst_data !== mem_word(hold)) begin fails++; $display("[TB] FAIL stall_hold cyc=%0d got valid=%b pc=%h data=%h exp pc=%h", k, inst_valid, inst_pc, inst_data, hold); end
            tests++; if (dut.count !== 2'd2 || imem_addr !== hold + 32'd8) begin fails++; $display("[TB] FAIL stall_full cyc=%0d got count=%0d addr=%h exp 2/%h", k, dut.count, imem_addr, hold + 32'd8); end
        end
        tests++; if (delivered !== d0) begin fails++; $display("[TB] FAIL stall_no_pop got=%0d exp=%0d", delivered, d0); end
        inst_ready = 1'b1;
        d0 = delivered;
        repeat (4) tick;
        tests++; if (delivered - d0 !== 4) begin fails++; $display("[TB] FAIL resume_rate got=%0d exp=4", delivered - d0); end
        inst_ready = 1'b0;
        repeat (2) tick;
        while (got_pc_q.size() > 0) begin
            gp = got_pc_q.pop_front(); gd = got_data_q.pop_front();
            if (exp_q.size() > 0) ep = exp_q.pop_front(); else ep = 32'hFFFF_FFFF;
            tests++;
            if (gp !== ep || gd !== mem_word(ep)) begin fails++; $display("[TB] FAIL stall_order got pc=%h data=%h exp pc=%h data=%h", gp, gd, ep, mem_word(ep)); end
            else $display("[TB] deliver pc=%h data=%h", gp, gd);
        end
    endtask

    task automatic test_redirect;
        logic [31:0] gp, gd, ep;
        tests++; if (dut.count !== 2'd2) begin fails++; $display("[TB] FAIL redirect_pre_count got=%0d exp=2", dut.count); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h14;
        tick;
        redirect_valid = 1'b0;
        while (got_pc_q.size() > 0) begin
            gp = got_pc_q.pop_front(); gd = got_data_q.pop_front();
            if (exp_q.size() > 0) ep = exp_q.pop_front(); else ep = 32'hFFFF_FFFF;
            tests++;
            if (gp !== ep || gd !== mem_word(ep)) begin fails++; $display("[TB] FAIL redirect_order got pc=%h exp pc=%h", gp, ep); end
            else $display("[TB] deliver pc=%h data=%h", gp, gd);
        end
        exp_q.delete();
        for (int i = 0; i < 27; i++) exp_q.push_back(32'h14 + 32'(4 * i));
        tests++; if (inst_valid !== 1'b0 || dut.count !== 2'd0) begin fails++; $display("[TB] FAIL redirect_flush got valid=%b count=%0d exp 0/0", inst_valid, dut.count); end
        tests++; if (imem_addr !== 32'h14) begin fails++; $display("[TB] FAIL redirect_addr got=%h exp=00000014", imem_addr); end
        tick;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL redirect_e1 got valid=%b exp=0", inst_valid); end
        tick;
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h14) begin fails++; $display("[TB] FAIL redirect_e2 got valid=%b pc=%h exp 1/00000014", inst_valid, inst_pc); end
        $display("[TB] redirect to 00000014 taken");
    endtask

    task automatic test_seq_fault;
        int n;
        logic [31:0] gp, gd, ep;
        inst_ready = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 100) begin tick; n++; end
        tests++; if (state !== 2'd2) begin fails++; $display("[TB] FAIL seq_fault_state got=%0d exp=2 after %0d cycles", state, n); end
        tests++; if (fault !== 1'b1 || imem_addr !== MEM_END) begin fails++; $display("[TB] FAIL seq_fault_flag got fault=%b addr=%h exp 1/%h", fault, imem_addr, MEM_END); end
        n = 0;
        while (inst_valid === 1'b1 && n < 10) begin tick; n++; end
        while (got_pc_q.size() > 0) begin
            gp = got_pc_q.pop_front(); gd = got_data_q.pop_front();
            if (exp_q.size() > 0) ep = exp_q.pop_front(); else ep = 32'hFFFF_FFFF;
            tests++;
            if (gp !== ep || gd !== mem_word(ep)) begin fails++; $display("[TB] FAIL seq_order got pc=%h data=%h exp pc=%h data=%h", gp, gd, ep, mem_word(ep)); end
            else $display("[TB] deliver pc=%h data=%h", gp, gd);
        end
        tests++; if (exp_q.size() !== 0) begin fails++; $display("[TB] FAIL seq_drain got %0d undelivered exp 0", exp_q.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        start = 1'b1;
        tick;
        redirect_valid = 1'b0;
        start = 1'b0;
        tests++; if (state !== 2'd2 || imem_addr !== MEM_END || inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL fault_sticky got state=%0d addr=%h valid=%b exp 2/%h/0", state, imem_addr, inst_valid, MEM_END); end
        $display("[TB] sequential fault at %h", MEM_END);
    endtask

    task automatic test_reset_mid;
        logic [31:0] gp, gd, ep;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick;
        redirect_valid = 1'b0;
        tests++; if (state !== 2'd0 || imem_addr !== RESET_PC) begin fails++; $display("[TB] FAIL idle_redirect got state=%0d addr=%h exp 0/%h", state, imem_addr, RESET_PC); end
        for (int i = 0; i < 16; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (2) tick;
        repeat (3) tick;
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        tests++; if (inst_valid !== 1'b0 || state !== 2'd0) begin fails++; $display("[TB] FAIL async_reset got valid=%b state=%0d exp 0/0", inst_valid, state); end
        tests++; if (imem_addr !== RESET_PC || dut.count !== 2'd0 || fault !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_regs got addr=%h count=%0d fault=%b", imem_addr, dut.count, fault); end
        while (got_pc_q.size() > 0) begin
            gp = got_pc_q.pop_front(); gd = got_data_q.pop_front();
            if (exp_q.size() > 0) ep = exp_q.pop_front(); else ep = 32'hFFFF_FFFF;
            tests++;
            if (gp !== ep || gd !== mem_word(ep)) begin fails++; $display("[TB] FAIL pre_reset_order got pc=%h exp pc=%h", gp, ep); end
            else $display("[TB] deliver pc=%h data=%h", gp, gd);
        end
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (2) tick;
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst_data !== mem_word(RESET_PC)) begin fails++; $display("[TB] FAIL restart_first got valid=%b pc=%h data=%h exp pc=%h", inst_valid, inst_pc, inst_data, RESET_PC); end
        $display("[TB] restart after mid-stream reset at %h", RESET_PC);
    endtask

    task automatic test_redirect_fault;
        logic [31:0] hold;
        repeat (2) tick;
        hold = exp_q[0];
        tests++; if (got_pc_q.size() !== 0) begin fails++; $display("[TB] FAIL held_no_delivery got=%0d exp=0", got_pc_q.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h13;
        tick;
        redirect_valid = 1'b0;
        exp_q.delete();
        tests++; if (fault !== 1'b1 || state !== 2'd2) begin fails++; $display("[TB] FAIL bad_redirect got fault=%b state=%0d exp 1/2", fault, state); end
        tests++; if (inst_valid !== 1'b0 || imem_addr !== hold + 32'd8) begin fails++; $display("[TB] FAIL bad_redirect_flush got valid=%b addr=%h exp 0/%h", inst_valid, imem_addr, hold + 32'd8); end
        inst_ready = 1'b1;
        repeat (3) tick;
        tests++; if (inst_valid !== 1'b0 || imem_addr !== hold + 32'd8 || got_pc_q.size() !== 0) begin fails++; $display("[TB] FAIL bad_redirect_frozen got valid=%b addr=%h deliveries=%0d", inst_valid, imem_addr, got_pc_q.size()); end
        $display("[TB] misaligned redirect faulted, pc frozen at %h", hold + 32'd8);
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_seq_fault;
        test_reset_mid;
        test_redirect_fault;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
